wb_write_queue: RTL
===================

// Module: wb_write_queue
// PURPOSE
//  Parametrised successor to the register write-back unit. Selects the write-back data and destination,
//  then queues each result in a DEPTH-entry FIFO that drains into the register-file write port.
//  The write port may stall through wport_ready. The block forwards the newest queued value for one
//  read address so the operand-fetch stage sees results that are still pending.
//  Sits between the memory/ALU stage and the register file.
// PARAMETERS
//  DATA_W   32  datapath width of alu_result, ld_result, pc and wport_data
//  ADDR_W   4   register address width
//  DEPTH    4   queue entries; power of two, >= 2
//  RD_LSB   22  instruction bit index of the rd field LSB; rd = instruction[RD_LSB+ADDR_W-1:RD_LSB]
//  RA_ADDR  15  destination register used by call (return-address register)
//  PC_INC   1   value added to pc for the call link value
// PORTS
//  clk           in   1       clock; all state updates on the rising edge
//  rst           in   1       asynchronous, active-high reset
//  in_valid      in   1       upstream presents a retiring instruction
//  in_ready      out  1       queue can accept; equals !full
//  alu_result    in   DATA_W  ALU result
//  ld_result     in   DATA_W  load data
//  pc            in   DATA_W  pc of the instruction
//  instruction   in   32      instruction word (source of rd)
//  is_ld         in   1       instruction is a load
//  is_call       in   1       instruction is a call
//  is_wb         in   1       instruction writes a register
//  wport_enable  out  1       head entry is valid; equals !empty
//  wport_addr    out  ADDR_W  head destination; 0 when empty
//  wport_data    out  DATA_W  head data; 0 when empty
//  wport_ready   in   1       register file accepts the head entry this cycle
//  fwd_addr      in   ADDR_W  operand address to look up
//  fwd_hit       out  1       some queued entry targets fwd_addr
//  fwd_data      out  DATA_W  data of the newest matching entry; 0 when no hit
//  count         out  $clog2(DEPTH+1)  occupied entries
//  full, empty   out  1       count==DEPTH / count==0
// BEHAVIOUR
//  - Accept: the block accepts the inputs when in_valid && in_ready at a rising edge.
//  - An accepted instruction with is_wb=0 is consumed and dropped; nothing is enqueued.
//  - Data select on {is_call, is_ld}: 01 -> ld_result; 10 -> pc+PC_INC (mod 2^DATA_W);
//    00 and 11 -> alu_result.
//  - Address: RA_ADDR if is_call, else the rd field.
//  - Enqueue: the entry is written at the tail. It is visible on wport_* and fwd_* the cycle after
//    acceptance. Minimum latency is 1 cycle; there is no same-cycle bypass.
//  - Dequeue: the head is popped when wport_enable && wport_ready. The next entry is presented on the
//    following cycle.
//  - Simultaneous push and pop: count is unchanged and pointers both advance.
//    A push cannot occur while full, because in_ready=0 then, even if a pop happens in the same cycle.
//  - Pointers: ADDR bits of $clog2(DEPTH) that wrap modulo DEPTH. count tracks occupancy from 0 to DEPTH.
//  - Order: entries drain strictly FIFO, so two writes to the same register retire oldest first.
//  - Forwarding (combinational over valid entries only):
//    - the match nearest the tail (youngest) wins;
//    - an entry being popped this cycle still counts as a hit;
//    - an entry being pushed this cycle does not count as a hit.
//  - wport_ready while empty has no effect.
//  - Reset (async; also mid-operation): head, tail and count return to 0 and all queued entries are
//    discarded. Outputs: wport_enable=0, wport_addr=0, wport_data=0, fwd_hit=0, fwd_data=0,
//    empty=1, full=0, in_ready=1.
//  - Storage contents need no reset, but stale entries must never be observable.
// TESTING
//  1 Reset value check: assert rst during traffic.
//    -> Outputs take the reset values above asynchronously.
//    -> After release, the first push appears on wport one cycle later.
//  2 Mux select: wport_ready=1, pc=0x10, rd field=9.
//    - {call,ld}=00 -> addr 9, data=alu_result.
//    - 01 -> addr 9, data=ld_result.
//    - 10 -> addr 15, data=0x11.
//    - 11 -> addr 9, data=alu_result.
//    - is_wb=0 -> nothing enqueued, count stays 0.
//  3 Fill and stall: hold wport_ready=0 and push 4 writes (r1..r4).
//    -> full=1, in_ready=0, count=4, and a 5th in_valid is not accepted.
//    -> Release wport_ready: r1, r2, r3, r4 drain in order, one per cycle.
//  4 Forwarding: queue r5=0xA then r5=0xB, with wport_ready=0.
//    -> fwd_addr=5 gives fwd_hit=1, fwd_data=0xB.
//    -> fwd_addr=6 gives fwd_hit=0, fwd_data=0.
//  5 Wrap-around and simultaneous push/pop: run 10 back-to-back writes with wport_ready=1 throughout.
//    -> count stays 1 after the first cycle.
//    -> Data drains in order with no loss across pointer wrap.
//  6 Random stress: random in_valid and wport_ready.
//    -> Scoreboard checks FIFO order, count and fwd_data against a reference model.

Source files
------------

// File: rtl/wb_write_queue.sv
// Register write-back queue: selects result data and destination, buffers writes in a
// DEPTH-entry FIFO toward the register-file port, and forwards the youngest pending value.
module wb_write_queue #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 4,
    parameter int RD_LSB  = 22,
    parameter int RA_ADDR = 15,
    parameter int PC_INC  = 1,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] ld_result,
    input  logic [DATA_W-1:0] pc,
    input  logic [31:0]       instruction,
    input  logic              is_ld,
    input  logic              is_call,
    input  logic              is_wb,
    output logic              wport_enable,
    output logic [ADDR_W-1:0] wport_addr,
    output logic [DATA_W-1:0] wport_data,
    input  logic              wport_ready,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              push, pop;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] sel_addr;
    logic [PTR_W-1:0]  slot_idx [DEPTH];
    logic [DEPTH-1:0]  slot_hit;
    logic              unused_instr;

    assign unused_instr = ^instruction;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign count    = count_q;
    assign push     = in_valid && in_ready && is_wb;
    assign pop      = !empty && wport_ready;

    // A call+load combination is treated as a plain ALU write, so it keeps the rd destination too.
    always_comb begin
        sel_data = alu_result;
        sel_addr = instruction[RD_LSB +: ADDR_W];
        case ({is_call, is_ld})
            2'b01: sel_data = ld_result;
            2'b10: begin
                sel_data = pc + DATA_W'(PC_INC);
                sel_addr = ADDR_W'(RA_ADDR);
            end
            default: sel_data = alu_result;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= sel_addr;
            data_mem[tail_q] <= sel_data;
        end
    end

    assign wport_enable = !empty;
    assign wport_addr   = empty ? '0 : addr_mem[head_q];
    assign wport_data   = empty ? '0 : data_mem[head_q];

    // Slot gi is the entry gi places behind the head; only slots below count hold live data.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_idx[gi] = head_q + PTR_W'(gi);
            assign slot_hit[gi] = (CNT_W'(gi) < count_q) && (addr_mem[slot_idx[gi]] == fwd_addr);
        end
    endgenerate

    // Later slots overwrite earlier ones, so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_hit[k]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[slot_idx[k]];
            end
        end
    end

endmodule
